// File: rtl/mem_port_ctrl_if.sv
// Load/store request, response and memory-file signals between the datapath and mem_port_ctrl.
// The controller takes the slave side; the requester and memory file take the master side.
interface mem_port_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_byte;
    logic [ADDR_WIDTH:0]   req_addr;
    logic [15:0]           req_wdata;
    logic                  rsp_valid;
    logic [15:0]           rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data;
    logic                  mem_memw;
    logic [15:0]           mem_q;

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data, mem_memw
    );

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data, mem_memw
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Byte-addressed load/store front end for a 16-bit word memory file with a registered read port.
// Word stores complete in the accept cycle; loads and byte stores take one extra memory cycle.
module mem_port_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_ctrl_if.slave io_bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        RMW_WR  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_rsp_set;
    logic                  w_rdata_ld;
    logic [15:0]           w_rdata_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_lane;
    logic                  r_byte;
    logic [7:0]            r_wbyte;
    logic                  r_rsp_valid;
    logic [15:0]           r_rdata;

    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] word, input logic lane,
                                               input logic [7:0] b);
        return lane ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    // Gating with rst_n keeps the port closed while reset is held.
    assign w_ready  = (r_state == IDLE) & rst_n;
    assign w_accept = io_bus.req_valid & w_ready;

    assign io_bus.req_ready = w_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rdata;

    always_comb begin
        w_state_nxt     = r_state;
        io_bus.mem_addr = r_waddr;
        io_bus.mem_data = io_bus.req_wdata;
        io_bus.mem_memw = 1'b0;
        w_rsp_set       = 1'b0;
        w_rdata_ld      = 1'b0;
        w_rdata_nxt     = r_rdata;
        case (r_state)
            IDLE: begin
                io_bus.mem_addr = io_bus.req_addr[ADDR_WIDTH:1];
                if (w_accept) begin
                    if (io_bus.req_we && !io_bus.req_byte) begin
                        io_bus.mem_memw = 1'b1;
                        w_rsp_set       = 1'b1;
                    end else if (!io_bus.req_we) begin
                        w_state_nxt = LD_WAIT;
                    end else begin
                        w_state_nxt = RMW_WR;
                    end
                end
            end
            LD_WAIT: begin
                w_rsp_set   = 1'b1;
                w_rdata_ld  = 1'b1;
                w_rdata_nxt = r_byte ? {8'h00, lane_sel(io_bus.mem_q, r_lane)} : io_bus.mem_q;
                w_state_nxt = IDLE;
            end
            RMW_WR: begin
                // mem_q holds the target word read during the accept cycle.
                io_bus.mem_data = lane_merge(io_bus.mem_q, r_lane, r_wbyte);
                io_bus.mem_memw = 1'b1;
                w_rsp_set       = 1'b1;
                w_state_nxt     = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 16'h0000;
            r_waddr     <= '0;
            r_lane      <= 1'b0;
            r_byte      <= 1'b0;
            r_wbyte     <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_set;
            if (w_rdata_ld) begin
                r_rdata <= w_rdata_nxt;
            end
            if (w_accept) begin
                r_waddr <= io_bus.req_addr[ADDR_WIDTH:1];
                r_lane  <= io_bus.req_addr[0];
                r_byte  <= io_bus.req_byte;
                r_wbyte <= io_bus.req_wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized and directed bench for mem_port_ctrl with a memory-file model and a transaction-level reference.
module tb_mem_port_ctrl;

    localparam int AW = 10;

    typedef struct {
        int          cyc;
        logic        is_ld;
        logic [15:0] d;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic mem_init = 1'b0;
    int   busy_cyc = -1;
    logic [15:0] last_load = 16'h0000;
    logic [15:0] tb_mem [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] r_q;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    mem_port_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    // Memory file: registered read address, write on memw at posedge.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_memw) begin
            tb_mem[bus.mem_addr] <= bus.mem_data;
        end
        r_q <= tb_mem[bus.mem_addr];
    end
    assign bus.mem_q = r_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: applied at the accept cycle t.
    task automatic model(input logic we, input logic byt, input logic [10:0] addr,
                         input logic [15:0] wd, input int t);
        logic [9:0]  w;
        logic [15:0] v;
        logic [15:0] nv;
        int          sh;
        w  = 10'(addr >> 1);
        v  = ref_mem[w];
        sh = (addr % 2) * 8;
        chk("mem_addr_accept", 32'(bus.mem_addr), 32'(w));
        if (we && !byt) begin
            ref_mem[w] = wd;
            wr_q.push_back('{cyc: t, a: w, d: wd});
            rsp_q.push_back('{cyc: t + 1, is_ld: 1'b0, d: 16'h0});
        end else if (!we) begin
            nv = byt ? ((v >> sh) & 16'h00FF) : v;
            rsp_q.push_back('{cyc: t + 2, is_ld: 1'b1, d: nv});
            busy_cyc = t + 1;
        end else begin
            nv = (v & ~(16'h00FF << sh)) | ((wd & 16'h00FF) << sh);
            ref_mem[w] = nv;
            wr_q.push_back('{cyc: t + 1, a: w, d: nv});
            rsp_q.push_back('{cyc: t + 2, is_ld: 1'b0, d: 16'h0});
            busy_cyc = t + 1;
        end
    endtask

    task automatic do_req(input logic we, input logic byt, input logic [10:0] addr,
                          input logic [15:0] wd);
        logic acc;
        acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                model(we, byt, addr, wd, cyc);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle monitor: ready, memory writes and responses against the reference queues.
    always @(negedge clk) begin
        #1;
        if (mon_en && rst_n) begin
            chk("req_ready", 32'(bus.req_ready), 32'(cyc != busy_cyc));
            if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                chk("wr_missing", 32'd0, 32'd1);
                void'(wr_q.pop_front());
            end
            if (bus.mem_memw) begin
                if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                    chk("wr_spurious", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", 32'(bus.mem_addr), 32'(wr_q[0].a));
                    chk("wr_data", 32'(bus.mem_data), 32'(wr_q[0].d));
                    void'(wr_q.pop_front());
                end
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                chk("rsp_missing", 32'd0, 32'd1);
                void'(rsp_q.pop_front());
            end
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                    chk("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    if (rsp_q[0].is_ld) last_load = rsp_q[0].d;
                    chk(rsp_q[0].is_ld ? "rsp_load_data" : "rsp_store_keeps_rdata",
                        32'(bus.rsp_rdata), 32'(last_load));
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int mism;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 11'h010;
        bus.req_wdata = 16'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_memw", 32'(bus.mem_memw), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Word store then immediate load of the same word.
        do_req(1'b1, 1'b0, 11'h010, 16'hBEEF);
        do_req(1'b0, 1'b0, 11'h010, 16'h0000);
        idle(2);
        chk("raw_beef", 32'(bus.rsp_rdata), 32'hBEEF);

        // Byte load lanes.
        do_req(1'b1, 1'b0, 11'h010, 16'h12A5);
        do_req(1'b0, 1'b1, 11'h010, 16'h0000);
        idle(2);
        chk("byte_lane0", 32'(bus.rsp_rdata), 32'h00A5);
        do_req(1'b0, 1'b1, 11'h011, 16'h0000);
        idle(2);
        chk("byte_lane1", 32'(bus.rsp_rdata), 32'h0012);

        // Byte store read-modify-write on both lanes.
        do_req(1'b1, 1'b0, 11'h040, 16'h3456);
        do_req(1'b1, 1'b1, 11'h041, 16'hFFC3);
        do_req(1'b0, 1'b0, 11'h040, 16'h0000);
        idle(2);
        chk("rmw_hi", 32'(bus.rsp_rdata), 32'hC356);
        do_req(1'b1, 1'b1, 11'h040, 16'h007E);
        do_req(1'b0, 1'b0, 11'h040, 16'h0000);
        idle(2);
        chk("rmw_lo", 32'(bus.rsp_rdata), 32'hC37E);

        // Back-to-back word stores.
        for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 11'(2 * i), 16'(i + 1));
        idle(2);
        for (int i = 0; i < 4; i++) chk("b2b_mem", 32'(tb_mem[i]), 32'(i + 1));

        // Top byte address and misaligned word access.
        do_req(1'b0, 1'b0, 11'h7FF, 16'h0000);
        idle(2);
        chk("top_word", 32'(bus.rsp_rdata), 32'(ref_mem[1023]));
        do_req(1'b1, 1'b0, 11'h003, 16'hA1B2);
        idle(1);
        chk("misaligned_store", 32'(tb_mem[1]), 32'hA1B2);

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  op;
            logic [10:0] a;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047))
                                             : 11'($urandom_range(0, 31));
            do_req(op[0], op[1], a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        // Reset during the write cycle of a byte store drops it.
        mon_en = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_byte  = 1'b1;
        bus.req_addr  = 11'h061;
        bus.req_wdata = 16'h005A;
        @(negedge clk);
        chk("rmwrst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rmwrst_memw_before", 32'(bus.mem_memw), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmwrst_memw_in_rst", 32'(bus.mem_memw), 32'd0);
        chk("rmwrst_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rmwrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmwrst_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rmwrst_rsp_after", 32'(bus.rsp_valid), 32'd0);
        chk("rmwrst_rdata_after", 32'(bus.rsp_rdata), 32'h0);
        chk("rmwrst_word_kept", 32'(tb_mem[10'h030]), 32'(ref_mem[10'h030]));
        @(posedge clk);
        #1;
        last_load = 16'h0000;
        busy_cyc  = -1;
        mon_en    = 1'b1;
        do_req(1'b0, 1'b0, 11'h060, 16'h0000);
        idle(4);

        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        chk("final_mem_image", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
